// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core: instruction constants, the IF/ID
// pipeline record and small helpers used by the fetch stage.
package core_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013; // addi x0,x0,0

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            valid;
    logic            misalign;
  } ifid_t;

  // Bubble placed into Decode on reset or flush
  function automatic ifid_t ifid_bubble();
    ifid_t b;
    b.instr    = NOP_INSTR;
    b.pc       = '0;
    b.pc4      = '0;
    b.valid    = 1'b0;
    b.misalign = 1'b0;
    return b;
  endfunction

  // Redirect target with bit 0 cleared, as JALR does
  function automatic logic [XLEN-1:0] redirect_pc(input logic [XLEN-1:0] tgt);
    return {tgt[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Fetch-stage performance counters: valid fetches into Decode, Decode stall
// cycles and Decode flush cycles. All counters wrap at 2^32.
module fetch_perf_cnt
  import core_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_fetch,
  input  logic            i_stall,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_cnt_fetch,
  output logic [XLEN-1:0] o_cnt_stall,
  output logic [XLEN-1:0] o_cnt_flush
);

  logic [XLEN-1:0] r_cnt_fetch;
  logic [XLEN-1:0] r_cnt_stall;
  logic [XLEN-1:0] r_cnt_flush;

  // Count qualifying edges; natural overflow gives the modulo-2^32 wrap
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt_fetch <= '0;
      r_cnt_stall <= '0;
      r_cnt_flush <= '0;
    end else begin
      if (i_fetch) r_cnt_fetch <= r_cnt_fetch + 32'd1;
      if (i_stall) r_cnt_stall <= r_cnt_stall + 32'd1;
      if (i_flush) r_cnt_flush <= r_cnt_flush + 32'd1;
    end
  end

  assign o_cnt_fetch = r_cnt_fetch;
  assign o_cnt_stall = r_cnt_stall;
  assign o_cnt_flush = r_cnt_flush;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage plus IF/ID register of the 5-stage RV32I core.
// Holds the PC, drives the imem address and registers the fetched word into
// Decode under hazard-unit stall/flush control and Execute redirects.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        pc_sel_E,
  input  logic [31:0] pc_target_E,
  input  logic [31:0] instr_F,
  output logic [31:0] pc_F,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        valid_D,
  output logic        misalign_D,
  output logic [31:0] cnt_fetch,
  output logic [31:0] cnt_stall,
  output logic [31:0] cnt_flush
);

  logic [31:0] r_pc;
  logic        r_mis_f;     // current fetch came from a target with bit 1 set
  logic        r_started;   // first edge after reset release has happened
  ifid_t       r_ifid;

  logic [31:0] w_pc4_f;
  logic [31:0] w_pc_next;
  logic        w_mis_next;
  logic        w_ifid_load;
  ifid_t       w_ifid_new;

  assign w_pc4_f     = r_pc + 32'd4;
  assign w_ifid_load = !FlushD && !StallD;

  // Next-PC select: redirect beats stall, which beats sequential advance
  always_comb begin
    w_pc_next  = w_pc4_f;
    w_mis_next = 1'b0;
    if (pc_sel_E) begin
      w_pc_next  = redirect_pc(pc_target_E);
      w_mis_next = pc_target_E[1];
    end else if (StallF) begin
      w_pc_next  = r_pc;
      w_mis_next = r_mis_f;
    end
  end

  // PC register and misalign flag travelling with the current fetch
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc    <= RESET_PC;
      r_mis_f <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_mis_f <= w_mis_next;
    end
  end

  // Started flag gates fetch counting until the pipeline is live
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_started <= 1'b0;
    else          r_started <= 1'b1;
  end

  // Record loaded into Decode on a normal advance
  always_comb begin
    w_ifid_new          = ifid_bubble();
    w_ifid_new.instr    = instr_F;
    w_ifid_new.pc       = r_pc;
    w_ifid_new.pc4      = w_pc4_f;
    w_ifid_new.valid    = 1'b1;
    w_ifid_new.misalign = r_mis_f;
  end

  // IF/ID register: flush beats stall
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)       r_ifid <= ifid_bubble();
    else if (FlushD)    r_ifid <= ifid_bubble();
    else if (!StallD)   r_ifid <= w_ifid_new;
  end

  assign pc_F       = r_pc;
  assign instr_D    = r_ifid.instr;
  assign pc_D       = r_ifid.pc;
  assign pc4_D      = r_ifid.pc4;
  assign valid_D    = r_ifid.valid;
  assign misalign_D = r_ifid.misalign;

`ifdef FETCH_PERF_EN
  logic w_fetch_inc;
  assign w_fetch_inc = w_ifid_load && r_started;

  fetch_perf_cnt u_perf (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_fetch     (w_fetch_inc),
    .i_stall     (StallD),
    .i_flush     (FlushD),
    .o_cnt_fetch (cnt_fetch),
    .o_cnt_stall (cnt_stall),
    .o_cnt_flush (cnt_flush)
  );
`else
  // Counters absent: only the perf block consumes these qualifiers
  logic w_perf_unused;
  assign w_perf_unused = r_started ^ w_ifid_load;
  assign cnt_fetch = '0;
  assign cnt_stall = '0;
  assign cnt_flush = '0;
`endif

endmodule
